// File: rtl/spi_reg_bridge.sv
// SPI byte-stream command decoder driving a local 8-bit register file.
// Optional macro SPI_REG_AUTOINC_EN: auto-increment the pointer after every data byte.
module spi_reg_bridge #(
  parameter int          NUM_REGS  = 16,
  parameter logic [7:0]  RESET_VAL = 8'h00,
  parameter logic [7:0]  FILL_BYTE = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cs_n,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  output logic [7:0]              tx_byte,
  output logic [8*NUM_REGS-1:0]   regs_o,
  output logic                    wr_pulse,
  output logic [6:0]              wr_addr,
  output logic                    err_o
);

`ifdef SPI_REG_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam logic [7:0] NUM_REGS_W = 8'(NUM_REGS);
  localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_t;

  state_t                  state_reg, state_next;
  logic [6:0]              ptr_reg, ptr_next;
  logic [7:0]              tx_reg, tx_next;
  logic                    err_reg, err_next;
  logic                    wr_pulse_reg;
  logic [6:0]              wr_addr_reg;
  logic [8*NUM_REGS-1:0]   regs_reg;

  logic                    wr_en;
  logic [7:0]              wr_data;
  logic [NUM_REGS-1:0]     wr_sel;
  logic [6:0]              ptr_inc;
  logic [6:0]              ptr_adv;
  logic [6:0]              rd_addr;
  logic [7:0]              rd_data;
  logic                    rd_in_range;
  logic                    ptr_in_range;

  assign ptr_inc      = (ptr_reg == LAST_ADDR) ? 7'd0 : ptr_reg + 7'd1;
  assign ptr_adv      = AUTOINC ? ptr_inc : ptr_reg;
  // CMD reads the address straight off the wire; RDATA reads the (possibly advanced) pointer.
  assign rd_addr      = (state_reg == CMD) ? rx_byte[6:0] : ptr_adv;
  assign rd_in_range  = {1'b0, rd_addr} < NUM_REGS_W;
  assign ptr_in_range = {1'b0, ptr_reg} < NUM_REGS_W;
  // Reg 0 bit 7 is a write-one-to-clear strobe for err_o and never stored.
  assign wr_data      = (ptr_reg == 7'd0) ? {1'b0, rx_byte[6:0]} : rx_byte;

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr == 7'(i)) rd_data = regs_reg[8*i +: 8];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_en && (ptr_reg == 7'(gi));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    tx_next    = tx_reg;
    err_next   = err_reg;
    wr_en      = 1'b0;
    if (cs_n) begin
      state_next = IDLE;
      ptr_next   = 7'd0;
      tx_next    = FILL_BYTE;
    end else begin
      case (state_reg)
        IDLE: state_next = CMD;
        CMD: begin
          if (rx_valid) begin
            ptr_next = rx_byte[6:0];
            if (rx_byte[7]) begin
              state_next = RDATA;
              tx_next    = rd_in_range ? rd_data : 8'h00;
              if (!rd_in_range) err_next = 1'b1;
            end else begin
              state_next = WDATA;
              tx_next    = FILL_BYTE;
            end
          end
        end
        WDATA: begin
          if (rx_valid) begin
            ptr_next = ptr_adv;
            if (ptr_in_range) begin
              wr_en = 1'b1;
              if (ptr_reg == 7'd0 && rx_byte[7]) err_next = 1'b0;
            end else begin
              err_next = 1'b1;
            end
          end
        end
        RDATA: begin
          if (rx_valid) begin
            ptr_next = ptr_adv;
            tx_next  = rd_in_range ? rd_data : 8'h00;
            if (!rd_in_range) err_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      ptr_reg      <= 7'd0;
      tx_reg       <= FILL_BYTE;
      err_reg      <= 1'b0;
      wr_pulse_reg <= 1'b0;
      wr_addr_reg  <= 7'd0;
      regs_reg     <= {NUM_REGS{RESET_VAL}};
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      tx_reg       <= tx_next;
      err_reg      <= err_next;
      wr_pulse_reg <= wr_en;
      if (wr_en) wr_addr_reg <= ptr_reg;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs_reg[8*i +: 8] <= wr_data;
      end
    end
  end

  assign tx_byte  = tx_reg;
  assign regs_o   = regs_reg;
  assign wr_pulse = wr_pulse_reg;
  assign wr_addr  = wr_addr_reg;
  assign err_o    = err_reg;

endmodule
